// File: rtl/bit_deserializer.sv
// bit_deserializer: receives start-bit framed serial words (LSB first) with optional
// even parity, and presents each word on a valid/ready output register with overrun detection.
`default_nettype none

module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_perr,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;

  logic             frame_done;
  logic [WIDTH-1:0] new_word;
  logic             new_perr;
  logic             accept;

  // Receive FSM: only d_valid cycles advance state, counter or shift register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    new_word   = shift_q;
    new_perr   = 1'b0;
    if (d_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!d) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        ST_DATA: begin
          shift_d[cnt_q] = d;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
            end else begin
              state_d    = ST_IDLE;
              frame_done = 1'b1;
              new_word   = shift_d;
            end
          end
        end
        ST_PARITY: begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
          new_word   = shift_q;
          new_perr   = (^shift_q) ^ d;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output register: a completed frame is dropped (and flagged) only when the
  // previous word is still waiting and is not being taken this cycle.
  assign accept = !valid_q || q_ready;

  always_comb begin
    word_d  = word_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_err) begin
      ovr_d = 1'b0;
    end
    if (frame_done) begin
      if (accept) begin
        word_d  = new_word;
        perr_d  = new_perr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && q_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q       = word_q;
  assign q_valid = valid_q;
  assign q_perr  = perr_q;
  assign overrun = ovr_q;

endmodule

`default_nettype wire
